// File: rtl/bus_router_pkg.sv
// Shared types and destination decode for bus_rr_router.
package bus_router_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned MAX_DRVRS = 16;
  localparam int unsigned SRC_W     = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    ROUTE = 3'd2,
    WAIT  = 3'd3,
    PUSH  = 3'd4
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_DRVRS-1:0] mask;
  } route_t;

  // Target mask for a destination id; broadcast reaches every device but the source.
  function automatic route_t dest_mask(input logic [ADDR_W-1:0] id,
                                       input logic [SRC_W-1:0]  src,
                                       input int unsigned       drvrs,
                                       input logic [ADDR_W-1:0] bcast);
    route_t r;
    r.valid = 1'b0;
    r.mask  = '0;
    if (id == bcast) begin
      for (int unsigned i = 0; i < MAX_DRVRS; i++) begin
        r.mask[SRC_W'(i)] = (i < drvrs) && (i != 32'(src));
      end
      r.valid = 1'b1;
    end else if ((32'(id) < drvrs) && (id != ADDR_W'(src))) begin
      r.mask[id[SRC_W-1:0]] = 1'b1;
      r.valid = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority request selector with a registered grant pointer.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 mode,
  input  logic                 advance,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] ptr;

  // Pointer holds the most recent grant; reset value gives index 0 first priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= IW'(N - 1);
    end else if (advance) begin
      ptr <= last_grant;
    end
  end

  // First pending request, searched from ptr+1 (round-robin) or from 0 (fixed).
  always_comb begin
    logic        found;
    int unsigned cand;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    any       = |req;
    for (int unsigned i = 0; i < N; i++) begin
      cand = mode ? ((32'(ptr) + 32'd1 + i) % N) : i;
      if (!found && req[IW'(cand)]) begin
        found             = 1'b1;
        grant_idx         = IW'(cand);
        grant[IW'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_router.sv
// Multi-device packet router: arbitrates source FIFOs, decodes the destination
// id in the packet's top byte, and pushes to one device or broadcasts.
// Optional statistics counters: define BUS_ROUTER_STATS_EN.
module bus_rr_router
  import bus_router_pkg::*;
#(
  parameter int unsigned DRVRS     = 4,
  parameter int unsigned PCKG_SZ   = 16,
  parameter logic [7:0]  BROADCAST = 8'hFF,
  parameter bit          ARB_MODE  = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DRVRS-1:0]           pndng,
  input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
  output logic [DRVRS-1:0]           pop,
  input  logic [DRVRS-1:0]           full,
  output logic [DRVRS-1:0]           push,
  output logic [DRVRS*PCKG_SZ-1:0]   D_push,
  output logic                       err
`ifdef BUS_ROUTER_STATS_EN
  ,
  output logic [DRVRS*16-1:0]        tx_count,
  output logic [15:0]                drop_count
`endif
);

  localparam int unsigned IDX_W = $clog2(DRVRS);

  state_t             state;
  logic [IDX_W-1:0]   src;
  logic [PCKG_SZ-1:0] pkt;
  logic [DRVRS-1:0]   mask;
  logic               route_ok;

  logic [DRVRS-1:0]   grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any;
  logic               advance;
  route_t             route;

  // Pointer moves past the source once its packet is delivered or dropped.
  always_comb begin
    advance = (state == PUSH) || ((state == ROUTE) && !route_ok);
  end

  // Destination decode of the selected source's head word.
  always_comb begin
    route = dest_mask(D_pop[src*PCKG_SZ + (PCKG_SZ - ADDR_W) +: ADDR_W],
                      SRC_W'(src), DRVRS, BROADCAST);
  end

  rr_arbiter #(
    .N(DRVRS)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (pndng),
    .mode      (ARB_MODE),
    .advance   (advance),
    .last_grant(src),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // Packet FSM: select, pop, decode, wait for room, push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      src      <= '0;
      pkt      <= '0;
      mask     <= '0;
      route_ok <= 1'b0;
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      err      <= 1'b0;
    end else begin
      pop  <= '0;
      push <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            src   <= grant_idx;
            pop   <= grant;
            state <= POP;
          end
        end
        POP: begin
          pkt      <= D_pop[src*PCKG_SZ +: PCKG_SZ];
          mask     <= route.mask[DRVRS-1:0];
          route_ok <= route.valid && (|route.mask);
          err      <= !(route.valid && (|route.mask));
          state    <= ROUTE;
        end
        ROUTE: begin
          if (!route_ok) begin
            state <= IDLE;
          end else if ((mask & full) == '0) begin
            push   <= mask;
            D_push <= {DRVRS{pkt}};
            state  <= PUSH;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if ((mask & full) == '0) begin
            push   <= mask;
            D_push <= {DRVRS{pkt}};
            state  <= PUSH;
          end
        end
        PUSH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef BUS_ROUTER_STATS_EN
  // Saturating per-source delivery and drop counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_count   <= '0;
      drop_count <= '0;
    end else begin
      if ((state == PUSH) && (tx_count[src*16 +: 16] != 16'hFFFF)) begin
        tx_count[src*16 +: 16] <= tx_count[src*16 +: 16] + 16'd1;
      end
      if ((state == ROUTE) && !route_ok && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end
`endif

endmodule
